riio_bias_ctrl: RTL and testbench
=================================

Name: riio_bias_ctrl

Overview:
- Digital sequencer for the EG1D80V bias/bandgap IO cell.
- Drives the cell's enable, startup-kick, trim and VBIAS-enable pins from one core clock domain.
- Watches the cell's active-low valid flag and asserts a clean READY to downstream IO/PLL logic.
- Owns trim updates so that trim codes never change while the bandgap is starting up.

Parameters:
STARTUP_CYC, 16, cycles BG_STARTUP_O is held high (1..255)
SETTLE_CYC, 64, cycles waited after valid or after a trim change before READY (1..4095)
TIMEOUT_CYC, 1024, maximum cycles in WAIT_VALID before FAULT (1..4095)
TRIM_BIAS_DEF, 4'd8, reset value of TRIM_BIAS_O
TRIM_CURV_DEF, 5'd16, reset value of TRIM_CURV_O
TRIM_VBG_DEF, 5'd16, reset value of TRIM_VBG_O

Ports:
CLK_I  in  1  core clock
RST_N_I  in  1  asynchronous active-low reset
ENABLE_I  in  1  level request to power the bias block
VBIAS_REQ_I  in  1  request to drive VBIAS while in RUN
TRIM_LOAD_I  in  1  single-cycle strobe; capture TRIM_*_I
TRIM_BIAS_I  in  4  new bias trim
TRIM_CURV_I  in  5  new curvature trim
TRIM_VBG_I  in  5  new bandgap trim
BG_VALID_N_I  in  1  from cell BG_VALID_N_O; asynchronous
EN_O  out  1  to cell EN_I
BG_STARTUP_O  out  1  to cell BG_STARTUP_I
EN_VBIAS_O  out  1  to cell EN_VBIAS_I
TRIM_BIAS_O  out  4  to cell TRIM_BIAS_I
TRIM_CURV_O  out  5  to cell TRIM_CURV_I
TRIM_VBG_O  out  5  to cell TRIM_VBG_I
READY_O  out  1  bias stable and usable
TRIM_BUSY_O  out  1  captured trim is pending, not yet applied
FAULT_O  out  1  sticky fault
STATE_O  out  3  current FSM state, for debug

Behaviour:
- Reset: all 1-bit outputs are 0; STATE_O = OFF; TRIM_*_O = *_DEF. The 2-flop synchronizer on BG_VALID_N_I resets to 1 and adds 2 cycles of latency. All outputs are registered.
- FSM states (encoding): OFF=0, STARTUP=1, WAIT_VALID=2, SETTLE=3, RUN=4, FAULT=5. A single 12-bit down-counter is shared by all timed states.
- ENABLE_I=0, any state: next state is OFF. EN_O, BG_STARTUP_O, EN_VBIAS_O, READY_O and FAULT_O go to 0. Trim outputs are retained. This priority is the highest.
- OFF to STARTUP: when ENABLE_I=1 and FAULT_O=0.
  - ENABLE_I rises at edge N: EN_O=1 and BG_STARTUP_O=1 from edge N+1.
  - BG_STARTUP_O stays high for exactly STARTUP_CYC cycles, then the FSM enters WAIT_VALID.
- WAIT_VALID: BG_STARTUP_O=0.
  - Synchronized valid_n=0 goes to SETTLE.
  - After TIMEOUT_CYC cycles without valid, the FSM goes to FAULT.
  - If valid and the timeout occur in the same cycle, valid wins.
- SETTLE: counts SETTLE_CYC cycles, then enters RUN.
  - READY_O=0 throughout.
  - EN_VBIAS_O is held at its previous value; it is 0 on first entry.
- RUN: READY_O=1 and EN_VBIAS_O=VBIAS_REQ_I, registered with 1-cycle latency.
- FAULT: EN_O=0 and FAULT_O=1. FAULT is left only through ENABLE_I=0 (to OFF), which clears FAULT_O. Re-enabling requires ENABLE_I to go low and then high again.
- Trim handling:
  - TRIM_LOAD_I captures all three inputs into a shadow register and sets TRIM_BUSY_O the next cycle.
  - In OFF or RUN, the shadow is copied to TRIM_*_O on the following cycle and TRIM_BUSY_O clears.
  - In RUN, applying a trim also forces RUN to SETTLE: READY_O drops the same cycle the trim outputs change, then the full SETTLE_CYC wait restarts.
  - In STARTUP, WAIT_VALID or SETTLE, the trim stays pending and is applied on the cycle of entry into RUN. The RUN-entry rule then sends the FSM straight back to SETTLE.
  - In FAULT, the trim is applied immediately.
  - A second TRIM_LOAD_I while busy overwrites the shadow; only the last value is applied.
- Reset mid-sequence: everything returns immediately to reset values; no partial sequence survives.

Optional Feature:
- Macro: RIIO_BIAS_CTRL_MONITOR_EN.
- Defined:
  - In RUN or SETTLE, synchronized valid_n=1 for 2 consecutive cycles goes to FAULT. EN_VBIAS_O and READY_O drop on entry.
  - An extra 8-bit saturating output LOSS_CNT_O counts these events. It resets to 0 on RST_N_I only.
- Not defined: valid loss after WAIT_VALID is ignored, LOSS_CNT_O does not exist, and FAULT is reachable only by timeout.

Test Plan:
- Default params, ENABLE_I=1, BG_VALID_N_I falls at cycle 30 -> EN_O=1 from cycle 1; BG_STARTUP_O=1 on cycles 1-16; READY_O=1 at cycle 30+2+64+1.
- BG_VALID_N_I held 1 -> FAULT_O=1 after 16+1024 cycles and EN_O=0; ENABLE_I low then high -> FAULT_O clears and the sequence restarts.
- TRIM_LOAD_I with BIAS=3 during STARTUP -> TRIM_BUSY_O=1 until RUN entry; TRIM_BIAS_O=3 then; READY_O stays 0 for a further 64 cycles.
- In RUN with VBIAS_REQ_I=1, TRIM_LOAD_I -> EN_VBIAS_O stays 1, READY_O drops for 64 cycles, new trims are visible 2 cycles after the strobe.
- ENABLE_I=0 mid-SETTLE, and RST_N_I pulse mid-STARTUP -> all outputs 0 next edge or immediately; trims are retained after the enable drop and are *_DEF after reset.
- With MONITOR_EN, BG_VALID_N_I pulses 1 for 1 cycle in RUN -> no fault; pulses 1 for 3 cycles -> FAULT_O=1 and LOSS_CNT_O=1.

Source files
------------

// File: rtl/riio_bias_ctrl.sv
// Sequencer for the EG1D80V bias/bandgap cell: power-up, startup kick, valid wait, settle, trim ownership.
// Optional valid-loss monitor and LOSS_CNT_O port enabled by defining RIIO_BIAS_CTRL_MONITOR_EN.
module riio_bias_ctrl #(
  parameter int unsigned STARTUP_CYC   = 16,
  parameter int unsigned SETTLE_CYC    = 64,
  parameter int unsigned TIMEOUT_CYC   = 1024,
  parameter logic [3:0]  TRIM_BIAS_DEF = 4'd8,
  parameter logic [4:0]  TRIM_CURV_DEF = 5'd16,
  parameter logic [4:0]  TRIM_VBG_DEF  = 5'd16
) (
  input  logic       CLK_I,
  input  logic       RST_N_I,
  input  logic       ENABLE_I,
  input  logic       VBIAS_REQ_I,
  input  logic       TRIM_LOAD_I,
  input  logic [3:0] TRIM_BIAS_I,
  input  logic [4:0] TRIM_CURV_I,
  input  logic [4:0] TRIM_VBG_I,
  input  logic       BG_VALID_N_I,
  output logic       EN_O,
  output logic       BG_STARTUP_O,
  output logic       EN_VBIAS_O,
  output logic [3:0] TRIM_BIAS_O,
  output logic [4:0] TRIM_CURV_O,
  output logic [4:0] TRIM_VBG_O,
  output logic       READY_O,
  output logic       TRIM_BUSY_O,
  output logic       FAULT_O,
  output logic [2:0] STATE_O
`ifdef RIIO_BIAS_CTRL_MONITOR_EN
  ,
  output logic [7:0] LOSS_CNT_O
`endif
);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_STARTUP = 3'd1,
    S_WAIT    = 3'd2,
    S_SETTLE  = 3'd3,
    S_RUN     = 3'd4,
    S_FAULT   = 3'd5
  } state_e;

  typedef struct packed {
    logic [3:0] bias;
    logic [4:0] curv;
    logic [4:0] vbg;
  } trim_t;

  localparam logic [11:0] STARTUP_LD = 12'(STARTUP_CYC - 1);
  localparam logic [11:0] SETTLE_LD  = 12'(SETTLE_CYC - 1);
  localparam logic [11:0] TIMEOUT_LD = 12'(TIMEOUT_CYC - 1);
  localparam trim_t       TRIM_DEF   = '{bias: TRIM_BIAS_DEF, curv: TRIM_CURV_DEF, vbg: TRIM_VBG_DEF};

  state_e      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [1:0]  sync_q;
  logic        valid_n_s;
  trim_t       shadow_q, shadow_d, trim_q, trim_d, trim_in;
  logic        busy_q, busy_d;
  logic        en_q, en_d, kick_q, kick_d, vbias_q, vbias_d;
  logic        ready_q, ready_d, fault_q, fault_d;
  logic        apply;
  logic        mon_fault;

  assign valid_n_s = sync_q[1];
  assign trim_in   = '{bias: TRIM_BIAS_I, curv: TRIM_CURV_I, vbg: TRIM_VBG_I};

`ifdef RIIO_BIAS_CTRL_MONITOR_EN
  logic       loss_q;
  logic [7:0] loss_cnt_q;

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      loss_q     <= 1'b1;
      loss_cnt_q <= 8'd0;
    end else begin
      loss_q <= valid_n_s;
      if (mon_fault && (loss_cnt_q != 8'hFF)) loss_cnt_q <= loss_cnt_q + 8'd1;
    end
  end

  assign LOSS_CNT_O = loss_cnt_q;
`endif

  // Two-flop synchronizer; idles at "not valid".
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], BG_VALID_N_I};
  end

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state_q  <= S_OFF;
      cnt_q    <= 12'd0;
      shadow_q <= TRIM_DEF;
      trim_q   <= TRIM_DEF;
      busy_q   <= 1'b0;
      en_q     <= 1'b0;
      kick_q   <= 1'b0;
      vbias_q  <= 1'b0;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      trim_q   <= trim_d;
      busy_q   <= busy_d;
      en_q     <= en_d;
      kick_q   <= kick_d;
      vbias_q  <= vbias_d;
      ready_q  <= ready_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    trim_d    = trim_q;
    busy_d    = busy_q;
    apply     = 1'b0;
    mon_fault = 1'b0;

    case (state_q)
      S_OFF: begin
        apply = busy_q;
        if (ENABLE_I) begin
          state_d = S_STARTUP;
          cnt_d   = STARTUP_LD;
        end
      end
      S_STARTUP: begin
        if (cnt_q == 12'd0) begin
          state_d = S_WAIT;
          cnt_d   = TIMEOUT_LD;
        end else begin
          cnt_d = cnt_q - 12'd1;
        end
      end
      S_WAIT: begin
        if (!valid_n_s) begin
          state_d = S_SETTLE;
          cnt_d   = SETTLE_LD;
        end else if (cnt_q == 12'd0) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q - 12'd1;
        end
      end
      S_SETTLE: begin
        // A trim held back during bring-up lands at RUN entry and restarts the settle window.
        if (cnt_q == 12'd0) begin
          if (busy_q) begin
            apply = 1'b1;
            cnt_d = SETTLE_LD;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          cnt_d = cnt_q - 12'd1;
        end
      end
      S_RUN: begin
        if (busy_q) begin
          apply   = 1'b1;
          state_d = S_SETTLE;
          cnt_d   = SETTLE_LD;
        end
      end
      S_FAULT: apply = busy_q;
      default: state_d = S_OFF;
    endcase

`ifdef RIIO_BIAS_CTRL_MONITOR_EN
    if ((state_q == S_RUN || state_q == S_SETTLE) && valid_n_s && loss_q) begin
      state_d   = S_FAULT;
      mon_fault = 1'b1;
    end
`endif

    if (!ENABLE_I) begin
      state_d   = S_OFF;
      mon_fault = 1'b0;
    end

    if (apply) begin
      trim_d = shadow_q;
      busy_d = 1'b0;
    end
    // A fresh strobe always wins the shadow, even on the cycle the old value is applied.
    if (TRIM_LOAD_I) begin
      shadow_d = trim_in;
      busy_d   = 1'b1;
    end

    en_d    = (state_d == S_STARTUP) || (state_d == S_WAIT) ||
              (state_d == S_SETTLE)  || (state_d == S_RUN);
    kick_d  = (state_d == S_STARTUP);
    ready_d = (state_d == S_RUN);
    fault_d = (state_d == S_FAULT);
    case (state_d)
      S_RUN:    vbias_d = VBIAS_REQ_I;
      S_SETTLE: vbias_d = vbias_q;
      default:  vbias_d = 1'b0;
    endcase
  end

  assign EN_O         = en_q;
  assign BG_STARTUP_O = kick_q;
  assign EN_VBIAS_O   = vbias_q;
  assign READY_O      = ready_q;
  assign FAULT_O      = fault_q;
  assign TRIM_BUSY_O  = busy_q;
  assign TRIM_BIAS_O  = trim_q.bias;
  assign TRIM_CURV_O  = trim_q.curv;
  assign TRIM_VBG_O   = trim_q.vbg;
  assign STATE_O      = state_q;

endmodule

// File: tb/tb_riio_bias_ctrl.sv
// Directed bench for riio_bias_ctrl: bring-up timing, trims, fault, enable drop and reset.
module tb_riio_bias_ctrl;

  logic       CLK_I, RST_N_I, ENABLE_I, VBIAS_REQ_I, TRIM_LOAD_I, BG_VALID_N_I;
  logic [3:0] TRIM_BIAS_I;
  logic [4:0] TRIM_CURV_I, TRIM_VBG_I;
  logic       EN_O, BG_STARTUP_O, EN_VBIAS_O, READY_O, TRIM_BUSY_O, FAULT_O;
  logic [3:0] TRIM_BIAS_O;
  logic [4:0] TRIM_CURV_O, TRIM_VBG_O;
  logic [2:0] STATE_O;
`ifdef RIIO_BIAS_CTRL_MONITOR_EN
  logic [7:0] LOSS_CNT_O;
`endif

  int chk  = 0;
  int pass = 0;

  riio_bias_ctrl dut (
    .CLK_I(CLK_I), .RST_N_I(RST_N_I), .ENABLE_I(ENABLE_I), .VBIAS_REQ_I(VBIAS_REQ_I),
    .TRIM_LOAD_I(TRIM_LOAD_I), .TRIM_BIAS_I(TRIM_BIAS_I), .TRIM_CURV_I(TRIM_CURV_I),
    .TRIM_VBG_I(TRIM_VBG_I), .BG_VALID_N_I(BG_VALID_N_I), .EN_O(EN_O),
    .BG_STARTUP_O(BG_STARTUP_O), .EN_VBIAS_O(EN_VBIAS_O), .TRIM_BIAS_O(TRIM_BIAS_O),
    .TRIM_CURV_O(TRIM_CURV_O), .TRIM_VBG_O(TRIM_VBG_O), .READY_O(READY_O),
    .TRIM_BUSY_O(TRIM_BUSY_O), .FAULT_O(FAULT_O), .STATE_O(STATE_O)
`ifdef RIIO_BIAS_CTRL_MONITOR_EN
    , .LOSS_CNT_O(LOSS_CNT_O)
`endif
  );

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge CLK_I);
    #1;
  endtask

  task automatic load_trim(input logic [3:0] b, input logic [4:0] c, input logic [4:0] v);
    TRIM_LOAD_I = 1'b1; TRIM_BIAS_I = b; TRIM_CURV_I = c; TRIM_VBG_I = v;
  endtask

  task automatic test_reset;
    RST_N_I = 1'b0; ENABLE_I = 1'b0; VBIAS_REQ_I = 1'b0; TRIM_LOAD_I = 1'b0;
    TRIM_BIAS_I = '0; TRIM_CURV_I = '0; TRIM_VBG_I = '0; BG_VALID_N_I = 1'b1;
    step(3);
    chk++; if ({EN_O, BG_STARTUP_O, EN_VBIAS_O, READY_O, TRIM_BUSY_O, FAULT_O} !== 6'b0)
      $display("FAIL rst_bits: got %b want 000000", {EN_O, BG_STARTUP_O, EN_VBIAS_O, READY_O, TRIM_BUSY_O, FAULT_O}); else pass++;
    chk++; if (STATE_O !== 3'd0) $display("FAIL rst_state: got %0d want 0", STATE_O); else pass++;
    chk++; if ({TRIM_BIAS_O, TRIM_CURV_O, TRIM_VBG_O} !== {4'd8, 5'd16, 5'd16})
      $display("FAIL rst_trim: got %0d/%0d/%0d want 8/16/16", TRIM_BIAS_O, TRIM_CURV_O, TRIM_VBG_O); else pass++;
    RST_N_I = 1'b1;
    step(1);
  endtask

  // Cycle numbers count edges after ENABLE_I is driven high.
  task automatic test_startup_run;
    ENABLE_I = 1'b1;
    step(1);
    chk++; if (EN_O !== 1'b1) $display("FAIL su_en_c1: got %b want 1", EN_O); else pass++;
    chk++; if (BG_STARTUP_O !== 1'b1) $display("FAIL su_kick_c1: got %b want 1", BG_STARTUP_O); else pass++;
    chk++; if (STATE_O !== 3'd1) $display("FAIL su_state_c1: got %0d want 1", STATE_O); else pass++;
    step(15);
    chk++; if (BG_STARTUP_O !== 1'b1) $display("FAIL su_kick_c16: got %b want 1", BG_STARTUP_O); else pass++;
    step(1);
    chk++; if (BG_STARTUP_O !== 1'b0) $display("FAIL su_kick_c17: got %b want 0", BG_STARTUP_O); else pass++;
    chk++; if (STATE_O !== 3'd2) $display("FAIL su_state_c17: got %0d want 2", STATE_O); else pass++;
    step(13);
    BG_VALID_N_I = 1'b0;
    step(2);
    chk++; if (STATE_O !== 3'd2) $display("FAIL su_sync_c32: got %0d want 2", STATE_O); else pass++;
    step(1);
    chk++; if (STATE_O !== 3'd3) $display("FAIL su_settle_c33: got %0d want 3", STATE_O); else pass++;
    step(63);
    chk++; if (READY_O !== 1'b0) $display("FAIL su_ready_c96: got %b want 0", READY_O); else pass++;
    step(1);
    chk++; if (READY_O !== 1'b1) $display("FAIL su_ready_c97: got %b want 1", READY_O); else pass++;
    chk++; if (STATE_O !== 3'd4) $display("FAIL su_state_c97: got %0d want 4", STATE_O); else pass++;
    chk++; if (EN_VBIAS_O !== 1'b0) $display("FAIL su_vbias_c97: got %b want 0", EN_VBIAS_O); else pass++;
  endtask

  task automatic test_trim_run;
    VBIAS_REQ_I = 1'b1;
    step(1);
    chk++; if (EN_VBIAS_O !== 1'b1) $display("FAIL tr_vbias_on: got %b want 1", EN_VBIAS_O); else pass++;
    load_trim(4'd5, 5'd7, 5'd9);
    step(1);
    TRIM_LOAD_I = 1'b0;
    chk++; if (TRIM_BUSY_O !== 1'b1) $display("FAIL tr_busy: got %b want 1", TRIM_BUSY_O); else pass++;
    chk++; if (TRIM_BIAS_O !== 4'd8) $display("FAIL tr_bias_old: got %0d want 8", TRIM_BIAS_O); else pass++;
    chk++; if (READY_O !== 1'b1) $display("FAIL tr_ready_s1: got %b want 1", READY_O); else pass++;
    step(1);
    chk++; if ({TRIM_BIAS_O, TRIM_CURV_O, TRIM_VBG_O} !== {4'd5, 5'd7, 5'd9})
      $display("FAIL tr_trim_new: got %0d/%0d/%0d want 5/7/9", TRIM_BIAS_O, TRIM_CURV_O, TRIM_VBG_O); else pass++;
    chk++; if (READY_O !== 1'b0) $display("FAIL tr_ready_drop: got %b want 0", READY_O); else pass++;
    chk++; if (TRIM_BUSY_O !== 1'b0) $display("FAIL tr_busy_clr: got %b want 0", TRIM_BUSY_O); else pass++;
    chk++; if (EN_VBIAS_O !== 1'b1) $display("FAIL tr_vbias_hold: got %b want 1", EN_VBIAS_O); else pass++;
    step(63);
    chk++; if (READY_O !== 1'b0) $display("FAIL tr_ready_s65: got %b want 0", READY_O); else pass++;
    step(1);
    chk++; if (READY_O !== 1'b1) $display("FAIL tr_ready_s66: got %b want 1", READY_O); else pass++;
  endtask

  task automatic test_enable_drop;
    ENABLE_I = 1'b0;
    step(1);
    chk++; if ({EN_O, EN_VBIAS_O, READY_O, STATE_O} !== 6'b0)
      $display("FAIL ed_run_off: got %b want 000000", {EN_O, EN_VBIAS_O, READY_O, STATE_O}); else pass++;
    step(1);
    ENABLE_I = 1'b1;
    step(20);
    chk++; if (STATE_O !== 3'd3) $display("FAIL ed_settle: got %0d want 3", STATE_O); else pass++;
    chk++; if (EN_VBIAS_O !== 1'b0) $display("FAIL ed_vbias_first: got %b want 0", EN_VBIAS_O); else pass++;
    ENABLE_I = 1'b0;
    VBIAS_REQ_I = 1'b0;
    step(1);
    chk++; if ({EN_O, BG_STARTUP_O, EN_VBIAS_O, READY_O, FAULT_O} !== 5'b0)
      $display("FAIL ed_bits: got %b want 00000", {EN_O, BG_STARTUP_O, EN_VBIAS_O, READY_O, FAULT_O}); else pass++;
    chk++; if (STATE_O !== 3'd0) $display("FAIL ed_state: got %0d want 0", STATE_O); else pass++;
    chk++; if ({TRIM_BIAS_O, TRIM_CURV_O, TRIM_VBG_O} !== {4'd5, 5'd7, 5'd9})
      $display("FAIL ed_trim_keep: got %0d/%0d/%0d want 5/7/9", TRIM_BIAS_O, TRIM_CURV_O, TRIM_VBG_O); else pass++;
  endtask

  // Valid already low: WAIT at c17, SETTLE c18..c81, deferred trim applied at c82, RUN at c146.
  task automatic test_trim_startup;
    ENABLE_I = 1'b1;
    step(3);
    load_trim(4'd4, 5'd1, 5'd2);
    step(1);
    load_trim(4'd3, 5'd10, 5'd20);
    step(1);
    TRIM_LOAD_I = 1'b0;
    chk++; if (TRIM_BUSY_O !== 1'b1) $display("FAIL ts_busy_c5: got %b want 1", TRIM_BUSY_O); else pass++;
    chk++; if (TRIM_BIAS_O !== 4'd5) $display("FAIL ts_hold_c5: got %0d want 5", TRIM_BIAS_O); else pass++;
    step(76);
    chk++; if (TRIM_BUSY_O !== 1'b1) $display("FAIL ts_busy_c81: got %b want 1", TRIM_BUSY_O); else pass++;
    chk++; if (TRIM_BIAS_O !== 4'd5) $display("FAIL ts_hold_c81: got %0d want 5", TRIM_BIAS_O); else pass++;
    step(1);
    chk++; if ({TRIM_BIAS_O, TRIM_CURV_O, TRIM_VBG_O} !== {4'd3, 5'd10, 5'd20})
      $display("FAIL ts_trim_c82: got %0d/%0d/%0d want 3/10/20", TRIM_BIAS_O, TRIM_CURV_O, TRIM_VBG_O); else pass++;
    chk++; if (TRIM_BUSY_O !== 1'b0) $display("FAIL ts_busy_c82: got %b want 0", TRIM_BUSY_O); else pass++;
    chk++; if (READY_O !== 1'b0) $display("FAIL ts_ready_c82: got %b want 0", READY_O); else pass++;
    step(63);
    chk++; if (READY_O !== 1'b0) $display("FAIL ts_ready_c145: got %b want 0", READY_O); else pass++;
    step(1);
    chk++; if (READY_O !== 1'b1) $display("FAIL ts_ready_c146: got %b want 1", READY_O); else pass++;
  endtask

  task automatic test_fault;
    ENABLE_I = 1'b0;
    BG_VALID_N_I = 1'b1;
    step(3);
    ENABLE_I = 1'b1;
    step(1040);
    chk++; if ({FAULT_O, EN_O, STATE_O} !== {1'b0, 1'b1, 3'd2})
      $display("FAIL fl_c1040: got %b want 01010", {FAULT_O, EN_O, STATE_O}); else pass++;
    step(1);
    chk++; if (FAULT_O !== 1'b1) $display("FAIL fl_fault: got %b want 1", FAULT_O); else pass++;
    chk++; if (EN_O !== 1'b0) $display("FAIL fl_en: got %b want 0", EN_O); else pass++;
    chk++; if (STATE_O !== 3'd5) $display("FAIL fl_state: got %0d want 5", STATE_O); else pass++;
    load_trim(4'd11, 5'd3, 5'd4);
    step(1);
    TRIM_LOAD_I = 1'b0;
    step(1);
    chk++; if ({TRIM_BIAS_O, TRIM_BUSY_O} !== {4'd11, 1'b0})
      $display("FAIL fl_trim: got %0d busy %b want 11 busy 0", TRIM_BIAS_O, TRIM_BUSY_O); else pass++;
    step(3);
    chk++; if (FAULT_O !== 1'b1) $display("FAIL fl_sticky: got %b want 1", FAULT_O); else pass++;
    ENABLE_I = 1'b0;
    step(1);
    chk++; if ({FAULT_O, STATE_O} !== 4'b0) $display("FAIL fl_clear: got %b want 0000", {FAULT_O, STATE_O}); else pass++;
    ENABLE_I = 1'b1;
    step(1);
    chk++; if ({STATE_O, EN_O, BG_STARTUP_O} !== {3'd1, 1'b1, 1'b1})
      $display("FAIL fl_restart: got %b want 00111", {STATE_O, EN_O, BG_STARTUP_O}); else pass++;
  endtask

  task automatic test_reset_mid;
    step(4);
    RST_N_I = 1'b0;
    #1;
    chk++; if ({EN_O, BG_STARTUP_O, FAULT_O, STATE_O} !== 6'b0)
      $display("FAIL rm_bits: got %b want 000000", {EN_O, BG_STARTUP_O, FAULT_O, STATE_O}); else pass++;
    chk++; if ({TRIM_BIAS_O, TRIM_CURV_O, TRIM_VBG_O} !== {4'd8, 5'd16, 5'd16})
      $display("FAIL rm_trim: got %0d/%0d/%0d want 8/16/16", TRIM_BIAS_O, TRIM_CURV_O, TRIM_VBG_O); else pass++;
    ENABLE_I = 1'b0;
    BG_VALID_N_I = 1'b0;
    step(2);
    RST_N_I = 1'b1;
    step(1);
  endtask

`ifdef RIIO_BIAS_CTRL_MONITOR_EN
  task automatic test_monitor;
    ENABLE_I = 1'b1;
    step(85);
    chk++; if ({READY_O, LOSS_CNT_O} !== {1'b1, 8'd0})
      $display("FAIL mon_run: got ready %b cnt %0d want 1/0", READY_O, LOSS_CNT_O); else pass++;
    BG_VALID_N_I = 1'b1;
    step(1);
    BG_VALID_N_I = 1'b0;
    step(5);
    chk++; if ({FAULT_O, READY_O} !== 2'b01) $display("FAIL mon_glitch: got %b want 01", {FAULT_O, READY_O}); else pass++;
    BG_VALID_N_I = 1'b1;
    step(3);
    BG_VALID_N_I = 1'b0;
    step(1);
    chk++; if ({FAULT_O, READY_O, EN_VBIAS_O} !== 3'b100)
      $display("FAIL mon_fault: got %b want 100", {FAULT_O, READY_O, EN_VBIAS_O}); else pass++;
    chk++; if (LOSS_CNT_O !== 8'd1) $display("FAIL mon_cnt: got %0d want 1", LOSS_CNT_O); else pass++;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_startup_run();
    test_trim_run();
    test_enable_drop();
    test_trim_startup();
    test_fault();
    test_reset_mid();
`ifdef RIIO_BIAS_CTRL_MONITOR_EN
    test_monitor();
`endif
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
